prng_core: RTL and testbench

Parametrised pseudo-random generator for the Tiny Tapeout top level. A 2·OUT_W-bit data LFSR and an OUT_W-bit control LFSR advance on an internal prescaler tick or on request. A per-bit 2:1 whitening mux reduces the data LFSR to an OUT_W-bit word under control-LFSR selection, and the word is presented with a valid/ready handshake and optional 7-segment decode. There are no derived clocks: everything runs on `clk` with a tick enable.

---
 rtl/prng_core.sv | 163 ++++++++++++++++
 tb/tb_prng_core.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prng_core.sv
// prng_core: 2*OUT_W-bit data LFSR and OUT_W-bit control LFSR with XNOR
// feedback, per-bit whitening mux, valid/ready output register with sticky
// overrun flag, and a prescaler tick for free-run stepping.
// Optional hex 7-segment decode of rnd_out is built when PRNG_SEG7_EN is
// defined; otherwise seg_out is tied to zero. The port list is the same in both builds.
module prng_core #(
   parameter int OUT_W    = 8,
   parameter int PRESCALE = 10_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   mode,
   input  logic                   step_req,
   input  logic                   seed_ld,
   input  logic [2*OUT_W-1:0]     seed_in,
   output logic [OUT_W-1:0]       rnd_out,
   output logic                   rnd_valid,
   input  logic                   rnd_ready,
   output logic                   overrun,
   output logic [7*OUT_W/4-1:0]   seg_out
);

   localparam int          DW = 2 * OUT_W;
   localparam int unsigned ND = OUT_W / 4;
   localparam int          PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   // Tap masks (bit n-1 set for 1-based tap n) for each supported LFSR width.
   function automatic logic [31:0] tap_mask(input int unsigned w);
      case (w)
         4:       tap_mask = 32'h0000_000C;
         8:       tap_mask = 32'h0000_00B8;
         16:      tap_mask = 32'h0000_D008;
         32:      tap_mask = 32'h8020_0003;
         default: tap_mask = '0;
      endcase
   endfunction

   localparam logic [31:0]      DMASK_FULL = tap_mask(DW);
   localparam logic [31:0]      CMASK_FULL = tap_mask(OUT_W);
   localparam logic [DW-1:0]    DMASK      = DMASK_FULL[DW-1:0];
   localparam logic [OUT_W-1:0] CMASK      = CMASK_FULL[OUT_W-1:0];

   logic [DW-1:0]    data_q,  data_d;
   logic [OUT_W-1:0] ctrl_q,  ctrl_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [OUT_W-1:0] out_q,   out_d;
   logic             valid_q, valid_d;
   logic             ovr_q,   ovr_d;

   logic [DW-1:0]    data_nx;
   logic [OUT_W-1:0] ctrl_nx;
   logic [OUT_W-1:0] mux_w;
   logic             tick;
   logic             step;
   logic             load;

   // LFSR successors and whitening mux of the current state.
   always_comb begin
      data_nx = {data_q[DW-2:0], ~^(data_q & DMASK)};
      ctrl_nx = {ctrl_q[OUT_W-2:0], ~^(ctrl_q & CMASK)};
      mux_w   = '0;
      for (int unsigned j = 0; j < OUT_W; j++) begin
         mux_w[j] = ctrl_q[j] ? data_q[2*j+1] : data_q[2*j];
      end
   end

   // Step/load qualification and next-state of every register.
   always_comb begin
      load    = en & seed_ld;
      tick    = (presc_q == PMAX);
      step    = en & ~seed_ld & (mode ? step_req : tick);

      data_d  = data_q;
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      out_d   = out_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      // Prescaler is cleared whenever disabled, loading, or in request mode.
      if (!en || seed_ld || mode || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      if (load) begin
         data_d  = (&seed_in) ? '0 : seed_in;
         ctrl_d  = (&seed_in[DW-1:OUT_W]) ? '0 : seed_in[DW-1:OUT_W];
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end else if (step) begin
         data_d  = data_nx;
         ctrl_d  = ctrl_nx;
         out_d   = mux_w;
         valid_d = 1'b1;
         if (valid_q && !rnd_ready) begin
            ovr_d = 1'b1;
         end
      end else if (en && valid_q && rnd_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         ctrl_q  <= '0;
         presc_q <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rnd_out   = out_q;
   assign rnd_valid = valid_q;
   assign overrun   = ovr_q;

`ifdef PRNG_SEG7_EN
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   // Hex digit decode, one gfedcba digit per nibble of rnd_out.
   always_comb begin
      seg_out = '0;
      for (int unsigned n = 0; n < ND; n++) begin
         seg_out[7*n +: 7] = seg7(out_q[4*n +: 4]);
      end
   end
`else
   assign seg_out = '0;
`endif

endmodule

// File: tb/tb_prng_core.sv
// Directed bench for prng_core: an OUT_W=8/PRESCALE=4 instance for the
// functional scenarios and an OUT_W=4/PRESCALE=1 instance for period and
// asynchronous reset.
module tb_prng_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef PRNG_SEG7_EN
   localparam logic [13:0] SEG8_RST = {7'h3F, 7'h3F};
   localparam logic [13:0] SEG8_AA  = {7'h77, 7'h77};
   localparam logic [6:0]  SEG4_RST = 7'h3F;
`else
   localparam logic [13:0] SEG8_RST = '0;
   localparam logic [13:0] SEG8_AA  = '0;
   localparam logic [6:0]  SEG4_RST = '0;
`endif

   // OUT_W = 8 instance
   logic        rst8_n, en8, mode8, step8, ld8, rdy8;
   logic [15:0] seed8;
   logic [7:0]  out8;
   logic        val8, ovr8;
   logic [13:0] seg8;

   prng_core #(.OUT_W(8), .PRESCALE(4)) u_dut8 (
      .clk(clk), .rst_n(rst8_n), .en(en8), .mode(mode8), .step_req(step8),
      .seed_ld(ld8), .seed_in(seed8), .rnd_out(out8), .rnd_valid(val8),
      .rnd_ready(rdy8), .overrun(ovr8), .seg_out(seg8)
   );

   // OUT_W = 4 instance
   logic        rst4_n, en4, mode4, step4, ld4, rdy4;
   logic [7:0]  seed4;
   logic [3:0]  out4;
   logic        val4, ovr4;
   logic [6:0]  seg4;

   prng_core #(.OUT_W(4), .PRESCALE(1)) u_dut4 (
      .clk(clk), .rst_n(rst4_n), .en(en4), .mode(mode4), .step_req(step4),
      .seed_ld(ld4), .seed_in(seed4), .rnd_out(out4), .rnd_valid(val4),
      .rnd_ready(rdy4), .overrun(ovr4), .seg_out(seg4)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int   first_ret;
   logic saw_ff;

   initial begin
      rst8_n = 1'b0; en8 = 1'b0; mode8 = 1'b0; step8 = 1'b0; ld8 = 1'b0;
      rdy8 = 1'b1; seed8 = '0;
      rst4_n = 1'b0; en4 = 1'b0; mode4 = 1'b0; step4 = 1'b0; ld4 = 1'b0;
      rdy4 = 1'b0; seed4 = '0;
      #12;

      // Reset state
      check("rst_out",   out8, 8'h00);
      check("rst_valid", val8, 1'b0);
      check("rst_ovr",   ovr8, 1'b0);
      check("rst_seg",   seg8, SEG8_RST);
      check("rst_data",  u_dut8.data_q, 16'h0000);
      check("rst_presc", u_dut8.presc_q, 2'd0);

      // Free-run from reset
      tick();
      rst8_n = 1'b1; rst4_n = 1'b1;
      en8 = 1'b1; mode8 = 1'b0; rdy8 = 1'b1;
      tick(); tick(); tick();
      check("fr_valid_pre", val8, 1'b0);
      check("fr_presc3",    u_dut8.presc_q, 2'd3);
      tick();
      check("fr_valid1", val8, 1'b1);
      check("fr_out1",   out8, 8'h00);
      check("fr_data1",  u_dut8.data_q, 16'h0001);
      check("fr_ctrl1",  u_dut8.ctrl_q, 8'h01);
      tick();
      check("fr_valid_drop", val8, 1'b0);
      tick(); tick();
      check("fr_data_hold", u_dut8.data_q, 16'h0001);
      tick();
      check("fr_data2",  u_dut8.data_q, 16'h0003);
      check("fr_valid2", val8, 1'b1);
      check("fr_out2",   out8, 8'h00);

      // Seed and mux
      mode8 = 1'b1; seed8 = 16'hAAAA; ld8 = 1'b1;
      tick();
      ld8 = 1'b0; step8 = 1'b1;
      check("sd_data",  u_dut8.data_q, 16'hAAAA);
      check("sd_ctrl",  u_dut8.ctrl_q, 8'hAA);
      check("sd_valid", val8, 1'b0);
      tick();
      step8 = 1'b0;
      check("mux_out",   out8, 8'hAA);
      check("mux_valid", val8, 1'b1);
      check("mux_seg",   seg8, SEG8_AA);
      check("mux_data",  u_dut8.data_q, 16'h5555);

      // Lockup substitution
      seed8 = 16'hFFFF; ld8 = 1'b1;
      tick();
      ld8 = 1'b0; step8 = 1'b1;
      check("lk_data0", u_dut8.data_q, 16'h0000);
      check("lk_ctrl0", u_dut8.ctrl_q, 8'h00);
      tick();
      step8 = 1'b0;
      check("lk_data1", u_dut8.data_q, 16'h0001);
      check("lk_ctrl1", u_dut8.ctrl_q, 8'h01);
      check("lk_out",   out8, 8'h00);

      // Overrun and handshake
      seed8 = 16'h1234; ld8 = 1'b1;
      tick();
      ld8 = 1'b0; rdy8 = 1'b0; step8 = 1'b1;
      check("ov_clear_valid", val8, 1'b0);
      tick();
      check("ov_out1",   out8, 8'h54);
      check("ov_valid1", val8, 1'b1);
      check("ov_ovr1",   ovr8, 1'b0);
      tick();
      step8 = 1'b0; rdy8 = 1'b1;
      check("ov_valid2", val8, 1'b1);
      check("ov_ovr2",   ovr8, 1'b1);
      tick();
      check("hs_valid", val8, 1'b0);
      check("hs_ovr",   ovr8, 1'b1);
      seed8 = 16'h00FF; ld8 = 1'b1; step8 = 1'b1;
      tick();
      ld8 = 1'b0; step8 = 1'b0;
      check("ov_seed_clr", ovr8, 1'b0);

      // Priority: that load also carried step_req
      check("pr_data",  u_dut8.data_q, 16'h00FF);
      check("pr_ctrl",  u_dut8.ctrl_q, 8'h00);
      check("pr_valid", val8, 1'b0);

      // Hold while disabled
      mode8 = 1'b0;
      tick(); tick();
      check("hd_presc2", u_dut8.presc_q, 2'd2);
      en8 = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("hd_data",  u_dut8.data_q, 16'h00FF);
      check("hd_valid", val8, 1'b0);
      check("hd_presc", u_dut8.presc_q, 2'd0);
      en8 = 1'b1;
      tick(); tick(); tick();
      check("hd_nostep", val8, 1'b0);
      tick();
      check("hd_step_valid", val8, 1'b1);
      check("hd_step_data",  u_dut8.data_q, 16'h01FE);

      // Period on the 4-bit instance
      en4 = 1'b1; mode4 = 1'b0; rdy4 = 1'b0; seed4 = 8'h05; ld4 = 1'b1;
      tick();
      ld4 = 1'b0;
      check("pd_seed", u_dut4.data_q, 8'h05);
      first_ret = -1;
      saw_ff = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (u_dut4.data_q == 8'hFF) saw_ff = 1'b1;
         if (u_dut4.data_q == 8'h05 && first_ret < 0) first_ret = i;
      end
      check("pd_period", first_ret, 255);
      check("pd_no_ff",  saw_ff, 1'b0);
      check("pd_valid",  val4, 1'b1);
      check("pd_ovr",    ovr4, 1'b1);

      // Asynchronous reset mid-run, away from any clock edge
      #2;
      rst4_n = 1'b0;
      #1;
      check("ar_out",   out4, 4'h0);
      check("ar_valid", val4, 1'b0);
      check("ar_ovr",   ovr4, 1'b0);
      check("ar_seg",   seg4, SEG4_RST);
      check("ar_data",  u_dut4.data_q, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
